// File: rtl/counter_cmd_seq.sv
// Command sequencer driving a threebitcounter's ld/inc/data_in, expanding LOAD,
// STEP and WAIT host commands into cycle-level strobes while mirroring the count.
module counter_cmd_seq #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic             halt,
  output logic             ld,
  output logic             inc,
  output logic [WIDTH-1:0] data_in,
  output logic             done,
  output logic [WIDTH-1:0] mirror
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_WAIT} state_t;

  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_WAIT = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             last;

  assign cmd_ready = (state == S_IDLE) && !rst;
  assign ld        = (state == S_LOAD);

  // inc and done react to halt/rst within the same cycle, so they are decoded
  // from the registered state rather than registered themselves.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    last = (remaining <= CNT_W'(1));
    inc  = 1'b0;
    done = 1'b0;
    unique case (state)
      S_LOAD: done = !rst;
      S_STEP: begin
        inc  = (remaining != '0) && !halt && !rst;
        done = !rst && ((remaining == '0) || ((remaining == CNT_W'(1)) && !halt));
      end
      S_WAIT: done = last && !rst;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      data_in   <= '0;
      mirror    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          // cmd_ready is implied here: IDLE and not in reset.
          if (cmd_valid) begin
            case (cmd_op)
              OP_LOAD: begin
                data_in <= cmd_arg[WIDTH-1:0];
                state   <= S_LOAD;
              end
              OP_STEP: begin
                remaining <= cmd_arg;
                state     <= S_STEP;
              end
              OP_WAIT: begin
                remaining <= cmd_arg;
                state     <= S_WAIT;
              end
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          mirror <= data_in;
          state  <= S_IDLE;
        end
        S_STEP: begin
          if (inc) begin
            remaining <= remaining - CNT_W'(1);
            mirror    <= mirror + WIDTH'(1);
          end
          if (done) state <= S_IDLE;
        end
        S_WAIT: begin
          if (last) state <= S_IDLE;
          else      remaining <= remaining - CNT_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Scoreboard bench for counter_cmd_seq: each command pushes its expected per-cycle
// outputs into a queue, which is drained and compared cycle by cycle.
module tb_counter_cmd_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       halt;
  logic       ld;
  logic       inc;
  logic [2:0] data_in;
  logic       done;
  logic [2:0] mirror;

  localparam logic [1:0] NOP = 2'b00, LOAD = 2'b01, STEP = 2'b10, WAIT = 2'b11;

  typedef struct packed {
    logic       rdy;
    logic       ld;
    logic       inc;
    logic       done;
    logic [2:0] din;
    logic [2:0] mir;
  } rec_t;

  rec_t exp_q[$];
  logic [2:0] m_mirror = '0;
  logic [2:0] m_din    = '0;
  int n_compared   = 0;
  int n_mismatched = 0;

  counter_cmd_seq #(.WIDTH(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .halt(halt), .ld(ld), .inc(inc),
    .data_in(data_in), .done(done), .mirror(mirror)
  );

  always #5 clk = ~clk;

  function automatic rec_t mk(input logic rdy, input logic l, input logic i,
                              input logic d, input logic [2:0] din, input logic [2:0] mir);
    rec_t r;
    r.rdy = rdy; r.ld = l; r.inc = i; r.done = d; r.din = din; r.mir = mir;
    return r;
  endfunction

  // Reference model: expected cycles of one command plus the following idle cycle.
  task automatic predict(input logic [1:0] op, input logic [7:0] arg, input logic [15:0] hmask);
    logic [7:0] r;
    int         n;
    case (op)
      LOAD: begin
        m_din = arg[2:0];
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, m_din, m_mirror));
        m_mirror = m_din;
      end
      STEP: begin
        r = arg;
        if (r == 8'd0) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, m_din, m_mirror));
        for (int i = 0; i < 64 && r != 8'd0; i++) begin
          if (i < 16 && hmask[i]) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, m_din, m_mirror));
          end else begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, r == 8'd1, m_din, m_mirror));
            m_mirror = m_mirror + 3'd1;
            r = r - 8'd1;
          end
        end
      end
      WAIT: begin
        n = (arg == 8'd0) ? 1 : int'(arg);
        for (int j = 0; j < n; j++)
          exp_q.push_back(mk(1'b0, 1'b0, 1'b0, j == n - 1, m_din, m_mirror));
      end
      default: ;
    endcase
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, m_din, m_mirror));
  endtask

  // Pops and compares every queued record, one per cycle, applying halt/rst per cycle.
  task automatic drain(input string name, input logic [15:0] hmask, input logic [15:0] rmask);
    int   n;
    rec_t got;
    rec_t want;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      halt = (i < 16) ? hmask[i] : 1'b0;
      rst  = (i < 16) ? rmask[i] : 1'b0;
      @(negedge clk);
      got  = mk(cmd_ready, ld, inc, done, data_in, mirror);
      want = exp_q.pop_front();
      n_compared++;
      if (got !== want) begin
        n_mismatched++;
        $display("FAIL %s cycle %0d: got rdy=%b ld=%b inc=%b done=%b din=%0d mir=%0d, expected rdy=%b ld=%b inc=%b done=%b din=%0d mir=%0d",
                 name, i, got.rdy, got.ld, got.inc, got.done, got.din, got.mir,
                 want.rdy, want.ld, want.inc, want.done, want.din, want.mir);
      end
      if (i < n - 1) begin
        @(posedge clk);
        #1;
        if (want.rdy) cmd_valid = 1'b0;
      end
    end
    halt = 1'b0;
  endtask

  task automatic issue(input string name, input logic [1:0] op, input logic [7:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    #1;
    n_compared++;
    if (cmd_ready !== 1'b1) begin
      n_mismatched++;
      $display("FAIL %s accept: cmd_ready=%b expected 1", name, cmd_ready);
    end
  endtask

  task automatic send(input string name, input logic [1:0] op, input logic [7:0] arg,
                      input logic [15:0] hmask);
    issue(name, op, arg);
    predict(op, arg, hmask);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    drain(name, hmask, 16'h0);
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_arg = '0; halt = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_compared++;
      if ({cmd_ready, ld, inc, done, data_in, mirror} !== 10'b0) begin
        n_mismatched++;
        $display("FAIL reset_hold: rdy=%b ld=%b inc=%b done=%b din=%0d mir=%0d expected all 0",
                 cmd_ready, ld, inc, done, data_in, mirror);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_compared++;
    if ({cmd_ready, ld, inc, done, data_in, mirror} !== 10'b10_0000_0000) begin
      n_mismatched++;
      $display("FAIL reset_release: rdy=%b ld=%b inc=%b done=%b din=%0d mir=%0d expected rdy=1 rest 0",
               cmd_ready, ld, inc, done, data_in, mirror);
    end
  endtask

  task automatic test_load;
    send("load5", LOAD, 8'd5, 16'h0);
  endtask

  task automatic test_wrap;
    send("step4_wrap", STEP, 8'd4, 16'h0);
  endtask

  task automatic test_halt;
    send("step3_halt", STEP, 8'd3, 16'b0110);
  endtask

  task automatic test_zero_and_handshake;
    send("step0", STEP, 8'd0, 16'h0);
    send("nop", NOP, 8'd9, 16'h0);
    send("wait0", WAIT, 8'd0, 16'h0);
    // WAIT 3 while a LOAD 6 is held on the bus from the cycle after acceptance.
    issue("wait3_held", WAIT, 8'd3);
    predict(WAIT, 8'd3, 16'h0);
    predict(LOAD, 8'd6, 16'h0);
    @(posedge clk);
    #1;
    cmd_op  = LOAD;
    cmd_arg = 8'd6;
    drain("wait3_held", 16'h0, 16'h0);
  endtask

  task automatic test_back_to_back;
    send("b2b_load7", LOAD, 8'd7, 16'h0);
    send("b2b_step1", STEP, 8'd1, 16'h0);
    send("b2b_wait2", WAIT, 8'd2, 16'hffff);
    send("b2b_load_hi", LOAD, 8'hfa, 16'hffff);
  endtask

  task automatic test_reset_mid;
    issue("step10_rst", STEP, 8'd10);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, m_din, m_mirror));
      m_mirror = m_mirror + 3'd1;
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, m_din, m_mirror));
    m_mirror = '0;
    m_din    = '0;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    drain("step10_rst", 16'h0, 16'b01000);
    send("load2_after_rst", LOAD, 8'd2, 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load();
    test_wrap();
    test_halt();
    test_zero_and_handshake();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
